// File: rtl/table_array_mp_pkg.sv
// Shared definitions for the multi-read-port table array: sequencer state encoding.
package table_array_mp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/table_array_rport.sv
// One combinational read port of the table array, with write-first bypass and
// zero-forcing while the clear sequencer owns the table.
module table_array_rport #(
  parameter int DBITS  = 32,
  parameter int ABITS  = 4,
  parameter int BYPASS = 1
) (
  input  logic [DBITS-1:0] mem [1<<ABITS],
  input  logic [ABITS-1:0] raddr,
  input  logic             busy,
  input  logic             wact,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata
);

  // A live write to the same address wins over the stored word when bypass is on.
  always_comb begin
    rdata = mem[raddr];
    if (busy) begin
      rdata = '0;
    end else if ((BYPASS != 0) && wact && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/table_array_mp.sv
// Multi-read-port table memory with a single write port and a hardware clear
// sequencer that zeroes one word per cycle after reset or on request.
module table_array_mp
  import table_array_mp_pkg::*;
#(
  parameter int    DBITS        = 32,
  parameter int    ABITS        = 4,
  parameter int    RPORTS       = 2,
  parameter int    BYPASS       = 1,
  parameter int    CLR_ON_RESET = 1,
  parameter string MFILE        = ""
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [RPORTS*ABITS-1:0] RADDR,
  output logic [RPORTS*DBITS-1:0] RDATA,
  input  logic                    WE,
  input  logic [ABITS-1:0]        WADDR,
  input  logic [DBITS-1:0]        WDATA,
  input  logic                    CLEAR,
  output logic                    BUSY
);

  localparam int WORDS = 1 << ABITS;

  (* ram_init_file = MFILE, ramstyle = "no_rw_check" *)
  logic [DBITS-1:0] mem [WORDS];

  state_t           state, stateNxt;
  logic [ABITS-1:0] cnt, cntNxt;
  logic             memWe;
  logic [ABITS-1:0] memAddr;
  logic [DBITS-1:0] memData;
  logic             wrActive;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= (CLR_ON_RESET != 0) ? ST_SWEEP : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // The sweep borrows the single write port; user writes only land in IDLE without CLEAR.
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    memWe    = 1'b0;
    memAddr  = WADDR;
    memData  = WDATA;
    case (state)
      ST_SWEEP: begin
        memWe   = 1'b1;
        memAddr = cnt;
        memData = '0;
        cntNxt  = cnt + ABITS'(1);
        if (cnt == ABITS'(WORDS - 1)) begin
          stateNxt = ST_IDLE;
        end
      end
      default: begin
        if (CLEAR) begin
          stateNxt = ST_SWEEP;
          cntNxt   = '0;
        end else if (WE) begin
          memWe = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  assign BUSY     = (state == ST_SWEEP);
  assign wrActive = (state == ST_IDLE) && !CLEAR && WE;

  for (genvar p = 0; p < RPORTS; p++) begin : g_rport
    table_array_rport #(
      .DBITS (DBITS),
      .ABITS (ABITS),
      .BYPASS(BYPASS)
    ) u_rport (
      .mem  (mem),
      .raddr(RADDR[p*ABITS +: ABITS]),
      .busy (BUSY),
      .wact (wrActive),
      .waddr(WADDR),
      .wdata(WDATA),
      .rdata(RDATA[p*DBITS +: DBITS])
    );
  end

endmodule

// File: tb/tb_table_array_mp.sv
// Directed self-checking bench: one instance with bypass and clear-on-reset, one without.
module tb_table_array_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, we, clear, busy;
  logic [7:0]  raddr;
  logic [63:0] rdata;
  logic [3:0]  waddr;
  logic [31:0] wdata;

  logic        resetB, weB, clearB, busyB;
  logic [7:0]  raddrB;
  logic [63:0] rdataB;
  logic [3:0]  waddrB;
  logic [31:0] wdataB;

  int checks = 0;
  int errors = 0;

  table_array_mp dutA (
    .CLK(clk), .RESET(reset), .RADDR(raddr), .RDATA(rdata), .WE(we),
    .WADDR(waddr), .WDATA(wdata), .CLEAR(clear), .BUSY(busy)
  );

  table_array_mp #(.BYPASS(0), .CLR_ON_RESET(0)) dutB (
    .CLK(clk), .RESET(resetB), .RADDR(raddrB), .RDATA(rdataB), .WE(weB),
    .WADDR(waddrB), .WDATA(wdataB), .CLEAR(clearB), .BUSY(busyB)
  );

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic weI, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] ra0, input logic [3:0] ra1, input logic clr);
    we    = weI;
    waddr = wa;
    wdata = wd;
    raddr = {ra1, ra0};
    clear = clr;
  endtask

  // Expect BUSY for exactly 16 samples with reads forced to zero, then idle.
  task automatic sweepCheck(input string tag);
    for (int k = 0; k < 16; k++) begin
      #1;
      checkOutput({tag, " busy"}, {31'b0, busy}, 32'd1);
      if (k == 0) checkOutput({tag, " rd gated"}, rdata[31:0], 32'h0);
      tick();
    end
    #1;
    checkOutput({tag, " idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; resetB = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0);
    weB = 1'b0; waddrB = '0; wdataB = '0; raddrB = '0; clearB = 1'b0;
    #1;
    checkOutput("reset busyA", {31'b0, busy}, 32'd1);
    checkOutput("reset busyB", {31'b0, busyB}, 32'd0);
    tick();
    tick();
    reset = 1'b0; resetB = 1'b0;
    sweepCheck("init sweep");

    for (int a = 0; a < 16; a++) begin
      raddr = {4'(15 - a), 4'(a)};
      #1;
      checkOutput("init rd0", rdata[31:0], 32'h0);
      checkOutput("init rd1", rdata[63:32], 32'h0);
    end
    tick();

    applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 4'd9, 4'd9, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd5, 4'd5, 1'b0);
    #1;
    checkOutput("wr5 rd0", rdata[31:0], 32'hDEADBEEF);
    checkOutput("wr5 rd1", rdata[63:32], 32'hDEADBEEF);
    raddr[7:4] = 4'd6;
    #1;
    checkOutput("addr6 rd1", rdata[63:32], 32'h0);

    applyStimulus(1'b1, 4'd3, 32'h1234, 4'd3, 4'd3, 1'b0);
    #1;
    checkOutput("bypass rd0", rdata[31:0], 32'h1234);
    checkOutput("bypass rd1", rdata[63:32], 32'h1234);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 1'b0);
    #1;
    checkOutput("wr3 stored", rdata[31:0], 32'h1234);

    weB = 1'b1; waddrB = 4'd3; wdataB = 32'h0; raddrB = 8'h00;
    tick();
    wdataB = 32'h1234; raddrB = 8'h33;
    #1;
    checkOutput("nobypass old", rdataB[31:0], 32'h0);
    tick();
    weB = 1'b0;
    #1;
    checkOutput("nobypass new", rdataB[31:0], 32'h1234);

    weB = 1'b1; waddrB = 4'd1; wdataB = 32'hA5;
    tick();
    weB = 1'b0; resetB = 1'b1;
    #1;
    checkOutput("B reset busy", {31'b0, busyB}, 32'd0);
    tick();
    resetB = 1'b0; raddrB = 8'h01;
    #1;
    checkOutput("B keep a5", rdataB[31:0], 32'hA5);
    checkOutput("B idle", {31'b0, busyB}, 32'd0);

    applyStimulus(1'b1, 4'd2, 32'h55, 4'd2, 4'd5, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd2, 32'h77, 4'd2, 4'd5, 1'b1);
    #1;
    checkOutput("clr no bypass", rdata[31:0], 32'h55);
    checkOutput("clr cycle idle", {31'b0, busy}, 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(k == 10, 4'd7, 32'h99, 4'd5, 4'd5, k == 12);
      #1;
      checkOutput("clr sweep busy", {31'b0, busy}, 32'd1);
      if (k == 2) checkOutput("busy gate rd0", rdata[31:0], 32'h0);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd7, 4'd2, 1'b0);
    #1;
    checkOutput("clr done", {31'b0, busy}, 32'd0);
    checkOutput("addr7 dropped", rdata[31:0], 32'h0);
    checkOutput("addr2 dropped", rdata[63:32], 32'h0);
    raddr = 8'h55;
    #1;
    checkOutput("addr5 cleared", rdata[31:0], 32'h0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    reset = 1'b1;
    #1;
    checkOutput("midsweep reset busy", {31'b0, busy}, 32'd1);
    tick();
    reset = 1'b0;
    sweepCheck("reset sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/table_array_mp.md
Name: table_array_mp

Overview:
Parametrised multi-read-port table memory for processor lookup structures (predictor, BTB and tag tables); successor to the single-read table array.
- Provides RPORTS combinational read ports, one synchronous write port and optional write-first bypass.
- A hardware clear sequencer zeroes every entry, one word per cycle, after reset or on request.
- BUSY tells the pipeline when the table is not usable.

Parameters:
DBITS, 32, data bits per entry
ABITS, 4, address bits; WORDS = 1<<ABITS
RPORTS, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = read of the address being written this cycle returns WDATA; 0 = returns old contents
CLR_ON_RESET, 1, 1 = reset starts a clear sweep; 0 = reset goes straight to IDLE and keeps MFILE contents
MFILE, "", RAM init file (ram_init_file attribute)

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
RADDR  in  RPORTS*ABITS  read addresses; port p at bits [p*ABITS +: ABITS]
RDATA  out  RPORTS*DBITS  read data; port p at bits [p*DBITS +: DBITS]
WE  in  1  write enable
WADDR  in  ABITS  write address
WDATA  in  DBITS  write data
CLEAR  in  1  request a full-table clear sweep
BUSY  out  1  high while sweeping; table contents not valid

Behaviour:
- State machine with two states, IDLE and SWEEP, plus a sweep counter CNT of width ABITS.
- RESET asserted (asynchronous):
  - CNT=0.
  - State=SWEEP if CLR_ON_RESET=1, else IDLE.
  - BUSY follows the state immediately, without waiting for a clock edge.
- SWEEP:
  - Each cycle writes 0 to mem[CNT] and increments CNT.
  - The cycle with CNT==WORDS-1 writes the last word; the next state is IDLE.
  - Sweep length is exactly WORDS cycles.
  - CNT wraps to 0 on exit.
- IDLE:
  - CLEAR=1 -> SWEEP next cycle, CNT=0.
  - Otherwise WE=1 -> mem[WADDR]<=WDATA at the rising edge.
- BUSY = (state==SWEEP). It is combinational from the state register, with no extra latency.
- While BUSY=1:
  - WE is ignored; the write is dropped, not queued.
  - CLEAR is ignored; the sweep does not restart.
  - All RDATA are forced to 0.
- Simultaneous CLEAR and WE in IDLE: clear wins and the write is dropped.
- Reads (IDLE):
  - RDATA[p] = mem[RADDR[p]], combinational with zero latency.
  - Written data is visible after the write edge.
- Bypass: if BYPASS=1 and WE=1 and state=IDLE and CLEAR=0 and WADDR==RADDR[p], then RDATA[p]=WDATA in the same cycle.
- Ports are fully independent. Any number of ports may read the same address, including the write address.
- Reset mid-sweep restarts from CNT=0 (when CLR_ON_RESET=1). Partially cleared contents are irrelevant because every word is rewritten.
- Memory array has no reset, so it still infers RAM with no_rw_check. Multi-port reads may replicate the RAM per port.

Decomposition:
- Shared package: state encodings ST_IDLE=1'b0 and ST_SWEEP=1'b1.
- Sub-module table_array_rport:
  - One read port: array read, bypass compare, busy-zero gating.
  - Instantiated RPORTS times in a generate loop.

Test Plan:
1. Reset with CLR_ON_RESET=1, ABITS=4 -> BUSY=1 for exactly 16 cycles after RESET deasserts, then 0; every address reads 0 on both ports.
2. IDLE: write 0xDEADBEEF to addr 5; next cycle RADDR0=5, RADDR1=5 -> both ports return 0xDEADBEEF; RADDR1=6 returns 0.
3. BYPASS=1: WE=1, WADDR=3, WDATA=0x1234, RADDR0=3 in the same cycle -> RDATA0=0x1234 that cycle. With BYPASS=0 -> old value (0), then 0x1234 next cycle.
4. Pulse CLEAR with WE=1 to addr 2 in the same cycle -> write dropped, BUSY=1 next cycle for 16 cycles. A WE to addr 7 mid-sweep is dropped; addr 7 reads 0 afterwards. A second CLEAR mid-sweep does not extend BUSY.
5. Assert RESET asynchronously at sweep cycle 8 (between edges) -> BUSY stays high, CNT=0; full 16-cycle sweep follows release.
6. CLR_ON_RESET=0 with MFILE preloading addr 1=0xA5 -> BUSY=0 after reset; addr 1 reads 0xA5.
